// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with 2-bit BHT counters looked up from the
// fetch PC, plus EX-side branch/jump resolution that drives a registered redirect on mispredict.
module branch_predict_unit #(
  parameter int         XLEN         = 32,
  parameter int         ENTRIES      = 16,
  parameter logic [1:0] COUNTER_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target,
  input  logic            ex_valid,
  input  logic [1:0]      ex_kind,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_immediate,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic            ex_zero,
  input  logic            ex_negate_zero,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  localparam logic [1:0] KIND_NONE = 2'b00;
  localparam logic [1:0] KIND_BR   = 2'b01;
  localparam logic [1:0] KIND_JAL  = 2'b10;
  localparam logic [1:0] KIND_JALR = 2'b11;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic            valid_q  [ENTRIES];
  logic [TAGW-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic            uncond_q [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];

  logic            redirect_q;
  logic            redirect_d;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] redirect_pc_d;
  logic [31:0]     count_q;
  logic [31:0]     count_d;

  logic [IDX-1:0]  if_idx_s;
  logic [TAGW-1:0] if_tag_s;
  logic            if_hit_s;
  logic [IDX-1:0]  ex_idx_s;
  logic [TAGW-1:0] ex_tag_s;
  logic            ex_hit_s;
  logic            taken_s;
  logic [XLEN-1:0] target_s;
  logic            live_s;
  logic            mis_s;
  logic            upd_s;
  logic            stale_s;
  logic            unused_s;

  assign if_idx_s = if_pc[IDX+1:2];
  assign if_tag_s = if_pc[XLEN-1:IDX+2];
  assign ex_idx_s = ex_pc[IDX+1:2];
  assign ex_tag_s = ex_pc[XLEN-1:IDX+2];
  assign unused_s = ^{if_pc[1:0], ex_pc[1:0], ex_alu_out[0]};

  // Fetch-side lookup reads the pre-update table contents
  always_comb begin
    if_hit_s       = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
    if_pred_taken  = if_hit_s && (uncond_q[if_idx_s] || ctr_q[if_idx_s][1]);
    if (if_pred_taken) begin
      if_pred_target = target_q[if_idx_s];
    end else begin
      if_pred_target = if_pc + XLEN'(4);
    end
  end

  // EX-side outcome, target and mispredict detection
  always_comb begin
    taken_s  = 1'b0;
    target_s = ex_pc + ex_immediate;
    case (ex_kind)
      KIND_NONE: taken_s = 1'b0;
      KIND_BR:   taken_s = ex_zero ^ ex_negate_zero;
      KIND_JAL:  taken_s = 1'b1;
      KIND_JALR: begin
        taken_s  = 1'b1;
        target_s = {ex_alu_out[XLEN-1:1], 1'b0};
      end
      default:   taken_s = 1'b0;
    endcase
    // The slot right after a redirect is wrong-path and must not act
    live_s   = ex_valid && !redirect_q;
    mis_s    = live_s && ((taken_s != ex_pred_taken) ||
                          (taken_s && (target_s != ex_pred_target)));
    upd_s    = live_s && (ex_kind != KIND_NONE);
    stale_s  = live_s && (ex_kind == KIND_NONE) && ex_pred_taken;
    ex_hit_s = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
  end

  // Next state of the redirect register and the saturating mispredict counter
  always_comb begin
    redirect_d    = mis_s;
    redirect_pc_d = redirect_pc_q;
    count_d       = count_q;
    if (mis_s) begin
      redirect_pc_d = taken_s ? target_s : (ex_pc + XLEN'(4));
      if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      redirect_pc_d = redirect_pc_q;
    end
  end

  // Redirect and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      count_q       <= 32'd0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      count_q       <= count_d;
    end
  end

  // Prediction table training on resolved control flow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        uncond_q[i] <= 1'b0;
        ctr_q[i]    <= COUNTER_INIT;
      end
    end else if (upd_s) begin
      if (taken_s) begin
        valid_q[ex_idx_s]  <= 1'b1;
        tag_q[ex_idx_s]    <= ex_tag_s;
        target_q[ex_idx_s] <= target_s;
        uncond_q[ex_idx_s] <= ex_kind[1];
        ctr_q[ex_idx_s]    <= sat_inc(ctr_q[ex_idx_s]);
      end else if (ex_hit_s) begin
        ctr_q[ex_idx_s]    <= sat_dec(ctr_q[ex_idx_s]);
      end
    end else if (stale_s) begin
      valid_q[ex_idx_s] <= 1'b0;
    end
  end

  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: table training, redirect timing, squash,
// aliasing, stale-hit clearing and asynchronous reset behaviour.
module tb_branch_predict_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [1:0]  ex_kind;
  logic [31:0] ex_pc;
  logic [31:0] ex_immediate;
  logic [31:0] ex_alu_out;
  logic        ex_zero;
  logic        ex_negate_zero;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16), .COUNTER_INIT(2'b01)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_kind(ex_kind),
    .ex_pc(ex_pc), .ex_immediate(ex_immediate), .ex_alu_out(ex_alu_out),
    .ex_zero(ex_zero), .ex_negate_zero(ex_negate_zero), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic zero, input logic neg,
                        input logic ptaken, input logic [31:0] ptarget);
    ex_valid       = 1'b1;
    ex_kind        = kind;
    ex_pc          = pc;
    ex_immediate   = imm;
    ex_alu_out     = alu;
    ex_zero        = zero;
    ex_negate_zero = neg;
    ex_pred_taken  = ptaken;
    ex_pred_target = ptarget;
  endtask

  // One EX instruction for one cycle, then EX goes idle
  task automatic resolve(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] alu, input logic zero, input logic neg,
                         input logic ptaken, input logic [31:0] ptarget);
    set_ex(kind, pc, imm, alu, zero, neg, ptaken, ptarget);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic expect_redirect(input string tag, input logic r, input logic [31:0] rpc,
                                 input logic [31:0] cnt);
    check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, r});
    check({tag, "_redirect_pc"}, redirect_pc, rpc);
    check({tag, "_count"}, mispredict_count, cnt);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic t,
                      input logic [31:0] tgt);
    if_pc = pc;
    #1;
    check({tag, "_pred_taken"}, {31'd0, if_pred_taken}, {31'd0, t});
    check({tag, "_pred_target"}, if_pred_target, tgt);
  endtask

  initial begin
    rst_n = 1'b0;
    if_pc = 32'h100;
    ex_valid = 1'b0; ex_kind = 2'b00; ex_pc = 32'd0; ex_immediate = 32'd0;
    ex_alu_out = 32'd0; ex_zero = 1'b0; ex_negate_zero = 1'b0;
    ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    #1;
    look("reset", 32'h100, 1'b0, 32'h104);
    expect_redirect("reset", 1'b0, 32'h0, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // BEQ taken, predicted not-taken
    resolve(2'b01, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_redirect("beq_taken", 1'b1, 32'h120, 32'd1);
    look("beq_trained", 32'h100, 1'b1, 32'h120);
    tick();
    expect_redirect("pulse_end", 1'b0, 32'h120, 32'd1);

    // Not-taken while predicted taken: counter 10 -> 01
    resolve(2'b01, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b1, 32'h120);
    expect_redirect("nt_mispred", 1'b1, 32'h104, 32'd2);
    tick();
    look("nt_weak", 32'h100, 1'b0, 32'h104);
    // Further correctly predicted not-taken: saturate at 00
    for (int i = 0; i < 4; i++) begin
      resolve(2'b01, 32'h100, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      check("nt_no_redirect", {31'd0, redirect}, 32'd0);
    end
    check("nt_count", mispredict_count, 32'd2);
    // One taken from 00 only reaches 01, still predicting not-taken
    resolve(2'b01, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_redirect("sat_probe", 1'b1, 32'h120, 32'd3);
    tick();
    look("sat_probe", 32'h100, 1'b0, 32'h104);

    // Second taken: entry predicts taken; aliasing PC 0x140 misses
    resolve(2'b01, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    expect_redirect("retrain", 1'b1, 32'h120, 32'd4);
    tick();
    look("retrain", 32'h100, 1'b1, 32'h120);
    look("alias_miss", 32'h140, 1'b0, 32'h144);

    // JALR overwrites the shared index
    resolve(2'b11, 32'h200, 32'h20, 32'h3001, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_redirect("jalr", 1'b1, 32'h3000, 32'd5);
    tick();
    look("jalr_hit", 32'h200, 1'b1, 32'h3000);
    look("jalr_evict", 32'h100, 1'b0, 32'h104);
    resolve(2'b11, 32'h200, 32'h20, 32'h3001, 1'b0, 1'b0, 1'b1, 32'h3000);
    expect_redirect("jalr_ok", 1'b0, 32'h3000, 32'd5);
    resolve(2'b11, 32'h200, 32'h20, 32'h3001, 1'b0, 1'b0, 1'b1, 32'h3004);
    expect_redirect("jalr_badtgt", 1'b1, 32'h3000, 32'd6);
    tick();

    // Mispredict followed by a wrong-path mismatching branch that must be squashed
    set_ex(2'b01, 32'h104, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    expect_redirect("squash_first", 1'b1, 32'h144, 32'd7);
    set_ex(2'b01, 32'h108, 32'h10, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    ex_valid = 1'b0;
    expect_redirect("squash_second", 1'b0, 32'h144, 32'd7);
    look("squash_noupd", 32'h108, 1'b0, 32'h10c);
    look("squash_first", 32'h104, 1'b1, 32'h144);

    // Stale hit on a non-control instruction clears the entry
    resolve(2'b00, 32'h104, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h144);
    expect_redirect("stale", 1'b1, 32'h108, 32'd8);
    tick();
    look("stale_clear", 32'h104, 1'b0, 32'h108);

    // BNE-style taken branch with negative offset
    resolve(2'b01, 32'h10c, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    expect_redirect("bne_back", 1'b1, 32'h0fc, 32'd9);
    tick();

    // Asynchronous reset in the middle of a redirect pulse
    resolve(2'b01, 32'h10c, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0fc);
    expect_redirect("pre_reset", 1'b1, 32'h110, 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    expect_redirect("async_reset", 1'b0, 32'h0, 32'd0);
    look("async_reset", 32'h10c, 1'b0, 32'h110);

    // Mispredict presented while reset is held is dropped
    resolve(2'b10, 32'h100, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    expect_redirect("reset_drop", 1'b0, 32'h0, 32'd0);
    rst_n = 1'b1;
    tick();

    // Correctly predicted JAL trains an unconditional entry without redirect
    resolve(2'b10, 32'h100, 32'h8, 32'h0, 1'b0, 1'b0, 1'b1, 32'h108);
    expect_redirect("jal_ok", 1'b0, 32'h0, 32'd0);
    look("jal_hit", 32'h100, 1'b1, 32'h108);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
